// File: rtl/memory_stage.sv
// MEM stage: issues data-memory accesses, aligns/extends load data, registers results for WB.
// Latency 1 cycle for non-memory ops, >=2 edges for aligned accesses; MEM_STALL holds upstream while busy.
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        MEMORY_CLOCK,
    input  logic        MEMORY_RESET,
    input  logic        EX_VALID,
    input  logic [31:0] EX_PC_4,
    input  logic [31:0] EX_ALU_RESULT,
    input  logic [31:0] EX_RS2,
    input  logic [1:0]  EX_RF_WR_SEL,
    input  logic        EX_REGWRITE,
    input  logic        EX_MEMWRITE,
    input  logic        EX_MEMREAD2,
    input  logic [1:0]  EX_SIZE,
    input  logic        EX_UNSIGNED,
    output logic        MEM_STALL,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WDATA,
    input  logic        DMEM_ACK,
    input  logic [31:0] DMEM_RDATA,
    output logic        MEM_VALID,
    output logic [31:0] MEM_PC_4,
    output logic [31:0] MEM_ALU_RESULT,
    output logic [31:0] MEM_DOUT2,
    output logic [1:0]  MEM_RF_WR_SEL,
    output logic        MEM_REGWRITE,
    output logic        MEM_FAULT
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, next_state;

    logic [CW-1:0] cnt;
    logic          access, misaligned, start, timeout;

    logic [31:0] cap_pc_4, cap_alu;
    logic [1:0]  cap_sel, cap_size;
    logic        cap_rw, cap_uns, cap_read;

    logic [3:0]  be_d;
    logic [31:0] wdata_d, lane, load_data;

    logic        wb_vld_d, wb_rw_d, wb_fault_d;
    logic [31:0] wb_pc_d, wb_alu_d, wb_dout_d;
    logic [1:0]  wb_sel_d;

    assign access     = EX_VALID & (EX_MEMWRITE | EX_MEMREAD2);
    assign misaligned = ((EX_SIZE == 2'b01) & EX_ALU_RESULT[0])
                      | (EX_SIZE[1] & (|EX_ALU_RESULT[1:0]));
    assign start      = access & ~misaligned;
    // An ack on the final counted cycle wins over the timeout.
    assign timeout    = (cnt == CNT_LAST) & ~DMEM_ACK;

    always_ff @(posedge MEMORY_CLOCK or posedge MEMORY_RESET) begin
        if (MEMORY_RESET) state <= IDLE;
        else              state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = BUSY;
            BUSY: if (DMEM_ACK | timeout) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = EX_RS2;
        case (EX_SIZE)
            2'b00: begin
                be_d    = 4'b0001 << EX_ALU_RESULT[1:0];
                wdata_d = {4{EX_RS2[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << EX_ALU_RESULT[1:0];
                wdata_d = {2{EX_RS2[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane      = DMEM_RDATA >> {cap_alu[1:0], 3'b000};
        load_data = DMEM_RDATA;
        case (cap_size)
            2'b00:   load_data = cap_uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_data = cap_uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: ;
        endcase
    end

    // Output process: upstream stall plus the value the WB register loads at the next edge.
    always_comb begin
        MEM_STALL  = 1'b0;
        wb_vld_d   = 1'b0;
        wb_pc_d    = '0;
        wb_alu_d   = '0;
        wb_dout_d  = '0;
        wb_sel_d   = '0;
        wb_rw_d    = 1'b0;
        wb_fault_d = 1'b0;
        case (state)
            IDLE: begin
                MEM_STALL = start;
                if (!start) begin
                    wb_vld_d   = EX_VALID;
                    wb_pc_d    = EX_PC_4;
                    wb_alu_d   = EX_ALU_RESULT;
                    wb_sel_d   = EX_RF_WR_SEL;
                    wb_fault_d = access & misaligned;
                    wb_rw_d    = EX_VALID & EX_REGWRITE & ~(access & misaligned);
                end
            end
            BUSY: begin
                MEM_STALL = ~DMEM_ACK & ~timeout;
                if (DMEM_ACK | timeout) begin
                    wb_vld_d   = 1'b1;
                    wb_pc_d    = cap_pc_4;
                    wb_alu_d   = cap_alu;
                    wb_sel_d   = cap_sel;
                    wb_fault_d = timeout;
                    wb_rw_d    = cap_rw & ~timeout;
                    wb_dout_d  = (DMEM_ACK & cap_read) ? load_data : 32'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge MEMORY_CLOCK or posedge MEMORY_RESET) begin
        if (MEMORY_RESET) begin
            cnt            <= '0;
            cap_pc_4       <= '0;
            cap_alu        <= '0;
            cap_sel        <= '0;
            cap_size       <= '0;
            cap_rw         <= 1'b0;
            cap_uns        <= 1'b0;
            cap_read       <= 1'b0;
            DMEM_REQ       <= 1'b0;
            DMEM_WE        <= 1'b0;
            DMEM_ADDR      <= '0;
            DMEM_BE        <= '0;
            DMEM_WDATA     <= '0;
            MEM_VALID      <= 1'b0;
            MEM_PC_4       <= '0;
            MEM_ALU_RESULT <= '0;
            MEM_DOUT2      <= '0;
            MEM_RF_WR_SEL  <= '0;
            MEM_REGWRITE   <= 1'b0;
            MEM_FAULT      <= 1'b0;
        end else begin
            if (state == BUSY && next_state == BUSY) cnt <= cnt + 1'b1;
            else                                      cnt <= '0;

            if (state == IDLE && start) begin
                cap_pc_4   <= EX_PC_4;
                cap_alu    <= EX_ALU_RESULT;
                cap_sel    <= EX_RF_WR_SEL;
                cap_size   <= EX_SIZE;
                cap_rw     <= EX_REGWRITE;
                cap_uns    <= EX_UNSIGNED;
                cap_read   <= EX_MEMREAD2;
                DMEM_REQ   <= 1'b1;
                DMEM_WE    <= EX_MEMWRITE;
                DMEM_ADDR  <= {EX_ALU_RESULT[31:2], 2'b00};
                DMEM_BE    <= be_d;
                DMEM_WDATA <= wdata_d;
            end else if (state == BUSY && next_state == IDLE) begin
                DMEM_REQ   <= 1'b0;
                DMEM_WE    <= 1'b0;
            end

            MEM_VALID      <= wb_vld_d;
            MEM_PC_4       <= wb_pc_d;
            MEM_ALU_RESULT <= wb_alu_d;
            MEM_DOUT2      <= wb_dout_d;
            MEM_RF_WR_SEL  <= wb_sel_d;
            MEM_REGWRITE   <= wb_rw_d;
            MEM_FAULT      <= wb_fault_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed plus randomized bench for memory_stage against an arithmetic reference model.
module tb_memory_stage;

    localparam int T = 4;

    logic        MEMORY_CLOCK, MEMORY_RESET;
    logic        EX_VALID, EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD2, EX_UNSIGNED;
    logic [31:0] EX_PC_4, EX_ALU_RESULT, EX_RS2;
    logic [1:0]  EX_RF_WR_SEL, EX_SIZE;
    logic        MEM_STALL, DMEM_REQ, DMEM_WE, DMEM_ACK;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [3:0]  DMEM_BE;
    logic        MEM_VALID, MEM_REGWRITE, MEM_FAULT;
    logic [31:0] MEM_PC_4, MEM_ALU_RESULT, MEM_DOUT2;
    logic [1:0]  MEM_RF_WR_SEL;

    int checks = 0;
    int errors = 0;

    memory_stage #(.TIMEOUT_CYCLES(T)) dut (
        .MEMORY_CLOCK(MEMORY_CLOCK), .MEMORY_RESET(MEMORY_RESET),
        .EX_VALID(EX_VALID), .EX_PC_4(EX_PC_4), .EX_ALU_RESULT(EX_ALU_RESULT),
        .EX_RS2(EX_RS2), .EX_RF_WR_SEL(EX_RF_WR_SEL), .EX_REGWRITE(EX_REGWRITE),
        .EX_MEMWRITE(EX_MEMWRITE), .EX_MEMREAD2(EX_MEMREAD2), .EX_SIZE(EX_SIZE),
        .EX_UNSIGNED(EX_UNSIGNED), .MEM_STALL(MEM_STALL), .DMEM_REQ(DMEM_REQ),
        .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
        .MEM_VALID(MEM_VALID), .MEM_PC_4(MEM_PC_4), .MEM_ALU_RESULT(MEM_ALU_RESULT),
        .MEM_DOUT2(MEM_DOUT2), .MEM_RF_WR_SEL(MEM_RF_WR_SEL),
        .MEM_REGWRITE(MEM_REGWRITE), .MEM_FAULT(MEM_FAULT)
    );

    initial MEMORY_CLOCK = 1'b0;
    always #5 MEMORY_CLOCK = ~MEMORY_CLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: sizes as byte counts, lanes via shifts/multiplies of plain integers.
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [1:0] size, input logic [31:0] addr);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int n = nbytes(size);
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] rs2);
        case (nbytes(size))
            1:       return (rs2 % 256) * 32'h01010101;
            2:       return (rs2 % 65536) * 32'h00010001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] addr,
                                           input logic uns, input logic [31:0] rdata);
        int n = nbytes(size);
        int bits = 8 * n;
        longint v;
        if (n == 4) return rdata;
        v = (longint'(rdata) >> (8 * (addr % 4))) % (64'd1 << bits);
        if (!uns && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    // One instruction through the stage; d = no-ack BUSY cycles before the ack, -1 = never ack.
    task automatic txn(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic we, input logic rd, input logic [1:0] size,
                       input logic uns, input logic rw, input int d, input logic [31:0] rdata);
        logic [31:0] pc = $urandom;
        logic [1:0]  sel = 2'($urandom);
        bit acc, mis, done;
        int nstall;
        EX_VALID = v; EX_PC_4 = pc; EX_ALU_RESULT = alu; EX_RS2 = rs2;
        EX_RF_WR_SEL = sel; EX_REGWRITE = rw; EX_MEMWRITE = we; EX_MEMREAD2 = rd;
        EX_SIZE = size; EX_UNSIGNED = uns;
        acc = v && (we || rd);
        mis = acc && m_mis(size, alu);
        #1;
        if (!acc || mis) begin
            chk("idle_stall", MEM_STALL, 1'b0);
            @(posedge MEMORY_CLOCK); #1;
            chk("no_req", DMEM_REQ, 1'b0);
            chk("wb_valid", MEM_VALID, v);
            if (v) begin
                chk("wb_pc", MEM_PC_4, pc);
                chk("wb_alu", MEM_ALU_RESULT, alu);
                chk("wb_sel", MEM_RF_WR_SEL, sel);
                chk("wb_dout_nonload", MEM_DOUT2, 32'h0);
            end
            chk("wb_regwrite", MEM_REGWRITE, v && rw && !mis);
            chk("wb_fault", MEM_FAULT, mis);
        end else begin
            chk("capture_stall", MEM_STALL, 1'b1);
            nstall = 1;
            @(posedge MEMORY_CLOCK); #1;
            chk("req", DMEM_REQ, 1'b1);
            chk("we", DMEM_WE, we);
            chk("addr", DMEM_ADDR, alu & ~32'h3);
            chk("be", DMEM_BE, m_be(size, alu));
            chk("wdata", DMEM_WDATA, m_wdata(size, rs2));
            chk("bubble", MEM_VALID, 1'b0);
            EX_VALID = 1'b0; EX_ALU_RESULT = $urandom; EX_RS2 = $urandom; EX_SIZE = 2'($urandom);
            done = 0;
            for (int k = 0; k < T && !done; k++) begin
                if (k == d) begin
                    // Next access presented in the ack cycle must not overlap.
                    DMEM_ACK = 1'b1; DMEM_RDATA = rdata;
                    EX_VALID = 1'b1; EX_MEMREAD2 = 1'b1; EX_MEMWRITE = 1'b0;
                    EX_SIZE = 2'd2; EX_ALU_RESULT = $urandom & ~32'h3;
                    #1;
                    chk("ack_stall", MEM_STALL, 1'b0);
                    @(posedge MEMORY_CLOCK); #1;
                    DMEM_ACK = 1'b0; EX_VALID = 1'b0;
                    chk("req_drop", DMEM_REQ, 1'b0);
                    chk("res_valid", MEM_VALID, 1'b1);
                    chk("res_pc", MEM_PC_4, pc);
                    chk("res_alu", MEM_ALU_RESULT, alu);
                    chk("res_sel", MEM_RF_WR_SEL, sel);
                    chk("res_dout", MEM_DOUT2, rd ? m_load(size, alu, uns, rdata) : 32'h0);
                    chk("res_regwrite", MEM_REGWRITE, rw);
                    chk("res_fault", MEM_FAULT, 1'b0);
                    chk("stall_len", nstall, d + 1);
                    done = 1;
                end else if (k == T - 1) begin
                    DMEM_RDATA = $urandom;
                    #1;
                    chk("req_last", DMEM_REQ, 1'b1);
                    @(posedge MEMORY_CLOCK); #1;
                    chk("to_req_drop", DMEM_REQ, 1'b0);
                    chk("to_valid", MEM_VALID, 1'b1);
                    chk("to_fault", MEM_FAULT, 1'b1);
                    chk("to_regwrite", MEM_REGWRITE, 1'b0);
                    chk("to_dout", MEM_DOUT2, 32'h0);
                    done = 1;
                end else begin
                    DMEM_RDATA = $urandom;
                    #1;
                    chk("busy_stall", MEM_STALL, 1'b1);
                    chk("busy_req", DMEM_REQ, 1'b1);
                    chk("busy_addr", DMEM_ADDR, alu & ~32'h3);
                    chk("busy_bubble", MEM_VALID, 1'b0);
                    nstall++;
                    @(posedge MEMORY_CLOCK); #1;
                end
            end
        end
    endtask

    initial begin
        MEMORY_RESET = 1'b1; EX_VALID = 0; EX_PC_4 = 0; EX_ALU_RESULT = 0; EX_RS2 = 0;
        EX_RF_WR_SEL = 0; EX_REGWRITE = 0; EX_MEMWRITE = 0; EX_MEMREAD2 = 0;
        EX_SIZE = 0; EX_UNSIGNED = 0; DMEM_ACK = 0; DMEM_RDATA = 0;
        #1;
        chk("rst_req", DMEM_REQ, 1'b0);
        chk("rst_we", DMEM_WE, 1'b0);
        chk("rst_addr", DMEM_ADDR, 32'h0);
        chk("rst_be", DMEM_BE, 4'h0);
        chk("rst_wdata", DMEM_WDATA, 32'h0);
        chk("rst_valid", MEM_VALID, 1'b0);
        chk("rst_dout", MEM_DOUT2, 32'h0);
        chk("rst_regwrite", MEM_REGWRITE, 1'b0);
        chk("rst_fault", MEM_FAULT, 1'b0);
        chk("rst_stall", MEM_STALL, 1'b0);
        @(posedge MEMORY_CLOCK); @(posedge MEMORY_CLOCK); #1;
        MEMORY_RESET = 1'b0;

        // ALU op without memory access
        txn(1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 0, 32'h0);
        // Signed byte load from top lane, ack after three waiting cycles
        txn(1'b1, 32'h103, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 3, 32'h80AABBCC);
        chk("byte_load_const", MEM_DOUT2, 32'hFFFFFF80);
        // Half store to upper half
        txn(1'b1, 32'h202, 32'hDEADBEEF, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1, 32'h0);
        // Misaligned word load
        txn(1'b1, 32'h301, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 0, 32'h0);
        // Timeout, then a late ack that must be ignored
        txn(1'b1, 32'h400, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, -1, 32'h0);
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'hCAFEF00D;
        #1;
        chk("late_ack_stall", MEM_STALL, 1'b0);
        @(posedge MEMORY_CLOCK); #1;
        DMEM_ACK = 1'b0;
        chk("late_ack_req", DMEM_REQ, 1'b0);
        chk("late_ack_valid", MEM_VALID, 1'b0);

        // Reset in the middle of a BUSY access
        EX_VALID = 1'b1; EX_ALU_RESULT = 32'h500; EX_MEMREAD2 = 1'b1; EX_MEMWRITE = 1'b0;
        EX_SIZE = 2'd2; EX_REGWRITE = 1'b1;
        @(posedge MEMORY_CLOCK); #1;
        EX_VALID = 1'b0;
        @(posedge MEMORY_CLOCK); #2;
        MEMORY_RESET = 1'b1;
        #1;
        chk("midrst_req", DMEM_REQ, 1'b0);
        chk("midrst_valid", MEM_VALID, 1'b0);
        chk("midrst_stall", MEM_STALL, 1'b0);
        @(posedge MEMORY_CLOCK); #1;
        MEMORY_RESET = 1'b0; DMEM_ACK = 1'b1; DMEM_RDATA = 32'h12345678;
        #1;
        chk("postrst_stall", MEM_STALL, 1'b0);
        @(posedge MEMORY_CLOCK); #1;
        DMEM_ACK = 1'b0;
        chk("postrst_ack_valid", MEM_VALID, 1'b0);
        chk("postrst_ack_req", DMEM_REQ, 1'b0);
        chk("postrst_ack_regwrite", MEM_REGWRITE, 1'b0);

        // Randomized mix of ALU ops, loads, stores, misaligned accesses and timeouts
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a = $urandom;
            int kind = $urandom_range(0, 2);
            int d = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, T - 1);
            if ($urandom_range(0, 2) != 0) a = a & ~32'h3 | 32'($urandom_range(0, 1) * 2);
            txn(($urandom_range(0, 7) != 0), a, $urandom, kind == 1, kind == 2,
                2'($urandom), 1'($urandom), 1'($urandom), d, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
